// File: rtl/i2c_lockstep_checker.sv
// i2c_lockstep_checker: compares two lockstep I2C masters.
// It tolerates short skew on the SCL/SDA drive lines and pairs up the
// received-data words with a bounded handshake. The first fault is kept
// in a sticky register, together with a saturating count of fault cycles.
module i2c_lockstep_checker #(
    parameter int DATA_W       = 24,
    parameter int SKEW_MAX     = 2,
    parameter int DONE_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              scl_a,
    input  logic              sda_a,
    input  logic              scl_b,
    input  logic              sda_b,
    input  logic              done_a,
    input  logic              done_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              match,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [CNT_W-1:0]  err_count
);

    // The skew counter must be able to hold SKEW_MAX+1, where it saturates.
    localparam int SKEW_W = $clog2(SKEW_MAX + 2);
    // The wait timer counts 1..DONE_TIMEOUT.
    localparam int TMR_W  = $clog2(DONE_TIMEOUT + 1);

    localparam logic [SKEW_W-1:0] SKEW_LIMIT = SKEW_W'(SKEW_MAX);
    localparam logic [TMR_W-1:0]  TMR_LIMIT  = TMR_W'(DONE_TIMEOUT);

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_LINE    = 3'b001;
    localparam logic [2:0] CODE_DATA    = 3'b010;
    localparam logic [2:0] CODE_DUP     = 3'b011;
    localparam logic [2:0] CODE_TIMEOUT = 3'b100;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT_A,
        D_WAIT_B,
        D_CMP
    } data_state_t;

    // ------------------------------------------------------------------
    // Line checker
    // ------------------------------------------------------------------
    logic              line_mismatch;
    logic              line_event;
    logic [SKEW_W-1:0] skew_cnt;

    assign line_mismatch = (scl_a != scl_b) || (sda_a != sda_b);
    // The event fires on the (SKEW_MAX+1)-th consecutive mismatch cycle only.
    assign line_event    = enable && line_mismatch && (skew_cnt == SKEW_LIMIT);

    // Count the consecutive mismatch cycles, then saturate one past the limit so each run yields a single event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skew_cnt <= '0;
        end else if (!enable || !line_mismatch) begin
            skew_cnt <= '0;
        end else if (skew_cnt <= SKEW_LIMIT) begin
            skew_cnt <= skew_cnt + SKEW_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Data handshake FSM
    // ------------------------------------------------------------------
    data_state_t       state;
    data_state_t       state_next;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] data_a_q;
    logic [DATA_W-1:0] data_b_q;
    logic              latch_a;
    logic              latch_b;
    logic              data_event;
    logic              dup_event;
    logic              tmo_event;

    // State register. Reset aborts any pending wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= D_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and event generation. D_CMP accepts new dones exactly as D_IDLE does.
    always_comb begin
        state_next = state;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        data_event = 1'b0;
        dup_event  = 1'b0;
        tmo_event  = 1'b0;
        if (!enable) begin
            state_next = D_IDLE;
        end else begin
            case (state)
                D_IDLE, D_CMP: begin
                    if (state == D_CMP && data_a_q != data_b_q) begin
                        data_event = 1'b1;
                    end
                    if (done_a && done_b) begin
                        latch_a    = 1'b1;
                        latch_b    = 1'b1;
                        state_next = D_CMP;
                    end else if (done_a) begin
                        latch_a    = 1'b1;
                        state_next = D_WAIT_B;
                    end else if (done_b) begin
                        latch_b    = 1'b1;
                        state_next = D_WAIT_A;
                    end else begin
                        state_next = D_IDLE;
                    end
                end
                D_WAIT_B: begin
                    if (done_b) begin
                        latch_b    = 1'b1;
                        dup_event  = done_a;
                        state_next = D_CMP;
                    end else if (done_a) begin
                        dup_event  = 1'b1;
                        state_next = D_IDLE;
                    end else if (timer == TMR_LIMIT) begin
                        tmo_event  = 1'b1;
                        state_next = D_IDLE;
                    end
                end
                D_WAIT_A: begin
                    if (done_a) begin
                        latch_a    = 1'b1;
                        dup_event  = done_b;
                        state_next = D_CMP;
                    end else if (done_b) begin
                        dup_event  = 1'b1;
                        state_next = D_IDLE;
                    end else if (timer == TMR_LIMIT) begin
                        tmo_event  = 1'b1;
                        state_next = D_IDLE;
                    end
                end
                default: begin
                    state_next = D_IDLE;
                end
            endcase
        end
    end

    // The wait timer reads 1 in the first wait cycle and advances while the wait persists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state_next == D_WAIT_A || state_next == D_WAIT_B) begin
            if (state_next != state) begin
                timer <= TMR_W'(1);
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end else begin
            timer <= '0;
        end
    end

    // Capture each master's word only alongside its accepted done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            if (latch_a) begin
                data_a_q <= data_a;
            end
            if (latch_b) begin
                data_b_q <= data_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault logging
    // ------------------------------------------------------------------
    logic       any_event;
    logic [2:0] event_code;

    assign any_event = line_event || data_event || dup_event || tmo_event;

    // Select the highest-priority event of this cycle.
    always_comb begin
        event_code = CODE_NONE;
        if (line_event) begin
            event_code = CODE_LINE;
        end else if (data_event) begin
            event_code = CODE_DATA;
        end else if (dup_event) begin
            event_code = CODE_DUP;
        end else if (tmo_event) begin
            event_code = CODE_TIMEOUT;
        end
    end

    // Sticky status. Clear beats a same-cycle event, and only the first fault sets the code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            err_count  <= '0;
        end else if (clear) begin
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            err_count  <= '0;
        end else if (any_event) begin
            fault <= 1'b1;
            if (!fault) begin
                fault_code <= event_code;
            end
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign match = ~fault;

endmodule

// File: tb/tb_i2c_lockstep_checker.sv
// Directed-vector bench for i2c_lockstep_checker.
// A second instance, with a 2-bit error counter, shares all stimulus so
// that counter saturation can be observed.
module tb_i2c_lockstep_checker;

    localparam int DATA_W = 24;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic              enable = 1'b1;
    logic              clear  = 1'b0;
    logic              scl_a  = 1'b1;
    logic              sda_a  = 1'b1;
    logic              scl_b  = 1'b1;
    logic              sda_b  = 1'b1;
    logic              done_a = 1'b0;
    logic              done_b = 1'b0;
    logic [DATA_W-1:0] data_a = '0;
    logic [DATA_W-1:0] data_b = '0;

    logic       match;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] err_count;
    logic       s_match;
    logic       s_fault;
    logic [2:0] s_fault_code;
    logic [1:0] s_err_count;

    int checks   = 0;
    int failures = 0;

    i2c_lockstep_checker #(
        .DATA_W(DATA_W), .SKEW_MAX(2), .DONE_TIMEOUT(64), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .scl_a(scl_a), .sda_a(sda_a), .scl_b(scl_b), .sda_b(sda_b),
        .done_a(done_a), .done_b(done_b), .data_a(data_a), .data_b(data_b),
        .match(match), .fault(fault), .fault_code(fault_code), .err_count(err_count)
    );

    i2c_lockstep_checker #(
        .DATA_W(DATA_W), .SKEW_MAX(2), .DONE_TIMEOUT(64), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .scl_a(scl_a), .sda_a(sda_a), .scl_b(scl_b), .sda_b(sda_b),
        .done_a(done_a), .done_b(done_b), .data_a(data_a), .data_b(data_b),
        .match(s_match), .fault(s_fault), .fault_code(s_fault_code), .err_count(s_err_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: count it and report a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check all sticky outputs of the main instance against an expected code/count
    task automatic checkState(input string tag, input logic [2:0] code, input int cnt);
        logic exp_fault;
        exp_fault = (code != 3'b000);
        checkOutput({tag, "/fault"}, {31'd0, fault}, {31'd0, exp_fault});
        checkOutput({tag, "/match"}, {31'd0, match}, {31'd0, ~exp_fault});
        checkOutput({tag, "/code"}, {29'd0, fault_code}, {29'd0, code});
        checkOutput({tag, "/count"}, {24'd0, err_count}, cnt);
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge
    task automatic applyStimulus(input logic sa, input logic da, input logic sb, input logic db,
                                 input logic dna, input logic dnb,
                                 input logic [DATA_W-1:0] wa, input logic [DATA_W-1:0] wb);
        scl_a  = sa;
        sda_a  = da;
        scl_b  = sb;
        sda_b  = db;
        done_a = dna;
        done_b = dnb;
        data_a = wa;
        data_b = wb;
        @(posedge clk);
        #1;
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 1, 0, 0, '0, '0);
    endtask

    task automatic busCycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic s;
            s = (i % 2) == 1;
            applyStimulus(s, ~s, s, ~s, 0, 0, '0, '0);
        end
    endtask

    task automatic doneA(input logic [DATA_W-1:0] w);
        applyStimulus(1, 1, 1, 1, 1, 0, w, '0);
    endtask

    task automatic doneB(input logic [DATA_W-1:0] w);
        applyStimulus(1, 1, 1, 1, 0, 1, '0, w);
    endtask

    task automatic doClear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(2);
        checkState("reset", 3'b000, 0);
        checkOutput("reset/sat_count", {30'd0, s_err_count}, 0);
        rst = 1'b1;
        idle(1);

        // Three identical transactions with equal words
        for (int tr = 0; tr < 3; tr++) begin
            busCycles(6);
            if (tr == 1) begin
                doneA(24'hA5C3F0);
                idle(3);
                doneB(24'hA5C3F0);
            end else begin
                applyStimulus(1, 1, 1, 1, 1, 1, 24'hA5C3F0, 24'hA5C3F0);
            end
            idle(2);
            checkState($sformatf("txn%0d", tr), 3'b000, 0);
        end

        // Skew within tolerance, then a 4-cycle run
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        idle(3);
        checkState("skew2", 3'b000, 0);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        checkState("skew_run2", 3'b000, 0);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        checkState("skew_run3", 3'b001, 1);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        checkState("skew_run4", 3'b001, 1);
        idle(2);
        checkState("skew_after", 3'b001, 1);
        doClear();
        checkState("clear1", 3'b000, 0);

        // Data mismatch, then equal words
        doneA(24'h123456);
        idle(4);
        doneB(24'h123457);
        checkState("data_t1", 3'b000, 0);
        idle(1);
        checkState("data_t2", 3'b010, 1);
        doClear();
        doneA(24'h123456);
        idle(4);
        doneB(24'h123456);
        idle(2);
        checkState("data_eq", 3'b000, 0);

        // Timeout boundary, then a late partner starting a fresh wait
        doneA(24'h00ABCD);
        idle(63);
        checkState("tmo_t64", 3'b000, 0);
        idle(1);
        checkState("tmo_t65", 3'b100, 1);
        doneB(24'h00BEEF);
        idle(3);
        doneA(24'h00BEEF);
        idle(2);
        checkState("tmo_late", 3'b100, 1);
        doClear();
        doneA(24'h00C0DE);
        idle(63);
        doneB(24'h00C0DE);
        checkState("tmo_edge_a", 3'b000, 0);
        idle(2);
        checkState("tmo_edge_b", 3'b000, 0);

        // Duplicate done, then both dones while waiting
        doneA(24'h111111);
        idle(2);
        doneA(24'h222222);
        checkState("dup", 3'b011, 1);
        doClear();
        doneA(24'h111111);
        idle(1);
        applyStimulus(1, 1, 1, 1, 1, 1, 24'h999999, 24'h111111);
        checkState("dup_both", 3'b011, 1);
        idle(1);
        checkState("dup_both_cmp", 3'b011, 1);
        doClear();

        // Line and data events in the same cycle, then first fault wins
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 1, 1, 1, 24'h0000AA, 24'h0000BB);
        applyStimulus(1, 0, 1, 1, 0, 0, '0, '0);
        checkState("line_data", 3'b001, 1);
        idle(1);
        checkState("line_data_b", 3'b001, 1);
        applyStimulus(1, 1, 1, 1, 1, 1, 24'h000010, 24'h000020);
        idle(1);
        checkState("first_wins", 3'b001, 2);

        // Disabled: sticky retained, no events
        enable = 1'b0;
        idle(2);
        checkState("dis_hold", 3'b001, 2);
        doClear();
        checkState("dis_clear", 3'b000, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 0, 0, '0, '0);
        doneA(24'h0F0F0F);
        idle(3);
        enable = 1'b1;
        idle(70);
        checkState("dis_quiet", 3'b000, 0);

        // Five timeouts: main counts 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            doneA(24'h000001);
            idle(64);
        end
        checkState("sat_main", 3'b100, 5);
        checkOutput("sat/count", {30'd0, s_err_count}, 3);
        checkOutput("sat/code", {29'd0, s_fault_code}, 3'b100);
        checkOutput("sat/match", {31'd0, s_match}, 0);

        // Asynchronous reset while waiting for B
        doneA(24'hABCDEF);
        idle(5);
        #3;
        rst = 1'b0;
        #1;
        checkState("async_rst", 3'b000, 0);
        checkOutput("async_rst/sat_count", {30'd0, s_err_count}, 0);
        checkOutput("async_rst/sat_fault", {31'd0, s_fault}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        doneB(24'h000055);
        idle(10);
        doneA(24'h000055);
        idle(2);
        checkState("fresh_wait", 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
